// File: rtl/rv_mem_pkg.sv
// Shared memory-stage definitions: DMEM size codes, RV32 load/store funct3
// values and the access-controller FSM states.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } ma_state_e;

    // The low two funct3 bits carry the access size; 011/110/111 map to none.
    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = MEM_BYTE;
            F3_H, F3_HU: f3_size = MEM_HALF;
            F3_W:        f3_size = MEM_WORD;
            default:     f3_size = MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load data according to funct3;
// purely combinational so the forwarding path can share it.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
            F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
            F3_BU:   data_out = {24'b0, data_in[7:0]};
            F3_HU:   data_out = {16'b0, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/ma_access_ctrl.sv
// Memory-access stage controller: aligned accesses go straight to DMEM,
// misaligned halfwords/words are split into byte accesses while stalling.
module ma_access_ctrl
    import rv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  req_valid,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic [1:0]            dmem_write,
    output logic [1:0]            dmem_read,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    output logic                  stall,
    output logic [31:0]           wb_load_data,
    output logic                  wb_load_valid,
    output logic                  misaligned
);

    ma_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_valid_q, wb_valid_d;

    mem_size_e   size;
    logic        active;
    logic        f3_ok;
    logic        aligned;
    logic [1:0]  last_idx;
    logic [31:0] assembled;
    logic [31:0] ext_in;
    logic [31:0] ext_out;

    always_comb begin
        size     = f3_size(req_funct3);
        active   = req_valid && (req_load || req_store);
        f3_ok    = (size != MEM_NONE) && !(req_store && req_funct3[2]);
        aligned  = (size == MEM_BYTE)
                || ((size == MEM_HALF) && !req_addr[0])
                || ((size == MEM_WORD) && (req_addr[1:0] == 2'b00));
        last_idx = (size == MEM_WORD) ? 2'd3 : 2'd1;
    end

    // The byte arriving this cycle is merged in so the final split byte
    // reaches the extender without waiting for another edge.
    always_comb begin
        assembled = asm_q;
        assembled[{cnt_q, 3'b000} +: 8] = dmem_rdata[7:0];
        ext_in = (state_q == SPLIT) ? assembled : dmem_rdata;
    end

    load_extend u_load_extend (
        .data_in  (ext_in),
        .funct3   (req_funct3),
        .data_out (ext_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        dmem_write = MEM_NONE;
        dmem_read  = MEM_NONE;
        dmem_addr  = '0;
        dmem_wdata = '0;
        stall      = 1'b0;
        misaligned = 1'b0;

        if (!RESET && active && f3_ok) begin
            if ((state_q == IDLE) && aligned) begin
                dmem_addr = req_addr;
                if (req_store) begin
                    dmem_write = size;
                    case (size)
                        MEM_BYTE: dmem_wdata = {24'b0, req_wdata[7:0]};
                        MEM_HALF: dmem_wdata = {16'b0, req_wdata[15:0]};
                        default:  dmem_wdata = req_wdata;
                    endcase
                end else begin
                    dmem_read  = size;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ext_out;
                end
            end else begin
                misaligned = 1'b1;
                dmem_addr  = req_addr + ADDR_WIDTH'(cnt_q);
                if (req_store) begin
                    dmem_write = MEM_BYTE;
                    dmem_wdata = {24'b0, req_wdata[{cnt_q, 3'b000} +: 8]};
                end else begin
                    dmem_read = MEM_BYTE;
                    asm_d     = assembled;
                end
                if (cnt_q == last_idx) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                    if (req_load) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ext_out;
                    end
                end else begin
                    stall   = 1'b1;
                    state_d = SPLIT;
                    cnt_d   = cnt_q + 2'd1;
                end
            end
        end else begin
            // A vanished request can only mean an abort; never linger in SPLIT.
            state_d = IDLE;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            asm_q      <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign wb_load_data  = wb_data_q;
    assign wb_load_valid = wb_valid_q;

endmodule

// File: tb/tb_ma_access_ctrl.sv
// Self-checking bench for ma_access_ctrl: a byte-array DMEM on the DUT side
// and an independent reference memory plus access model in the bench.
module tb_ma_access_ctrl;
    import rv_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  dmem_write, dmem_read;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, wb_load_valid, misaligned;
    logic [31:0] wb_load_data;

    logic [7:0]  mem [0:255] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  a1, a2, a3;
    logic [7:0]  rb0, rb1, rb2, rb3;

    int          vectors = 0;
    int          miscompares = 0;
    logic        prev_valid;
    logic [31:0] prev_data;

    always #5 CLK = ~CLK;

    ma_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_load      (req_load),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .dmem_write    (dmem_write),
        .dmem_read     (dmem_read),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .wb_load_data  (wb_load_data),
        .wb_load_valid (wb_load_valid),
        .misaligned    (misaligned)
    );

    // DMEM: 256-byte little-endian store, combinational read, write at the edge.
    assign a1  = dmem_addr[7:0] + 8'd1;
    assign a2  = dmem_addr[7:0] + 8'd2;
    assign a3  = dmem_addr[7:0] + 8'd3;
    assign rb0 = mem[dmem_addr[7:0]];
    assign rb1 = mem[a1];
    assign rb2 = mem[a2];
    assign rb3 = mem[a3];
    assign dmem_rdata = (dmem_read == 2'b00) ? 32'h0 :
                        (dmem_read == 2'b01) ? {24'h0, rb0} :
                        (dmem_read == 2'b10) ? {16'h0, rb1, rb0} :
                                               {rb3, rb2, rb1, rb0};

    always @(posedge CLK) begin
        if (dmem_write != 2'b00) mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
        if (dmem_write[1]) mem[a1] <= dmem_wdata[15:8];
        if (dmem_write == 2'b11) begin
            mem[a2] <= dmem_wdata[23:16];
            mem[a3] <= dmem_wdata[31:24];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drives one request starting just after a rising edge, checks every cycle
    // it occupies, and leaves the bench just after the edge ending it.
    task automatic applyStimulus(input logic valid, input logic load, input logic store,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        int          nb;
        int          cycles;
        bit          is_aligned;
        logic [1:0]  size_code;
        logic [31:0] mask;
        longint      val;
        logic [31:0] a;

        req_valid  = valid;
        req_load   = load;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;

        case (f3)
            3'b000, 3'b100: nb = 1;
            3'b001, 3'b101: nb = 2;
            3'b010:         nb = 4;
            default:        nb = 0;
        endcase
        if (store && f3[2]) nb = 0;
        if (!(valid && (load || store))) nb = 0;
        is_aligned = (nb != 0) && ((addr % nb) == 0);
        cycles     = (nb == 0 || is_aligned) ? 1 : nb;
        size_code  = (nb == 1) ? 2'b01 : (nb == 2) ? 2'b10 : (nb == 4) ? 2'b11 : 2'b00;
        mask       = (nb == 1) ? 32'h000000FF : (nb == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;

        val = 0;
        for (int i = 0; i < nb; i++) begin
            a = addr + i;
            val = val + (longint'(ref_mem[a[7:0]]) << (8 * i));
        end
        if (nb > 0 && nb < 4 && !f3[2] && val >= (longint'(1) << (8 * nb - 1)))
            val = val - (longint'(1) << (8 * nb));

        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            checkOutput("wb_valid", {31'b0, wb_load_valid}, {31'b0, (k == 0) ? prev_valid : 1'b0});
            if (k == 0 && prev_valid) checkOutput("wb_data", wb_load_data, prev_data);
            if (nb == 0) begin
                checkOutput("idle_write", {30'b0, dmem_write}, 32'h0);
                checkOutput("idle_read", {30'b0, dmem_read}, 32'h0);
                checkOutput("idle_addr", dmem_addr, 32'h0);
                checkOutput("idle_wdata", dmem_wdata, 32'h0);
                checkOutput("idle_stall", {31'b0, stall}, 32'h0);
                checkOutput("idle_misaligned", {31'b0, misaligned}, 32'h0);
            end else if (is_aligned) begin
                checkOutput("al_write", {30'b0, dmem_write}, {30'b0, store ? size_code : 2'b00});
                checkOutput("al_read", {30'b0, dmem_read}, {30'b0, load ? size_code : 2'b00});
                checkOutput("al_addr", dmem_addr, addr);
                checkOutput("al_stall", {31'b0, stall}, 32'h0);
                checkOutput("al_misaligned", {31'b0, misaligned}, 32'h0);
                if (store) checkOutput("al_wdata", dmem_wdata & mask, wdata & mask);
            end else begin
                checkOutput("sp_write", {30'b0, dmem_write}, {30'b0, store ? 2'b01 : 2'b00});
                checkOutput("sp_read", {30'b0, dmem_read}, {30'b0, load ? 2'b01 : 2'b00});
                checkOutput("sp_addr", dmem_addr, addr + k);
                checkOutput("sp_stall", {31'b0, stall}, {31'b0, k < nb - 1});
                checkOutput("sp_misaligned", {31'b0, misaligned}, 32'h1);
                if (store) checkOutput("sp_wdata", dmem_wdata, (wdata >> (8 * k)) & 32'hFF);
            end
            @(posedge CLK);
            #1;
        end

        if (store && nb > 0) begin
            for (int i = 0; i < nb; i++) begin
                a = addr + i;
                ref_mem[a[7:0]] = wdata[8 * i +: 8];
            end
        end
        prev_valid = load && (nb > 0);
        prev_data  = val[31:0];
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_write"}, {30'b0, dmem_write}, 32'h0);
        checkOutput({tag, "_read"}, {30'b0, dmem_read}, 32'h0);
        checkOutput({tag, "_addr"}, dmem_addr, 32'h0);
        checkOutput({tag, "_wdata"}, dmem_wdata, 32'h0);
        checkOutput({tag, "_stall"}, {31'b0, stall}, 32'h0);
        checkOutput({tag, "_wbdata"}, wb_load_data, 32'h0);
        checkOutput({tag, "_wbvalid"}, {31'b0, wb_load_valid}, 32'h0);
        checkOutput({tag, "_misaligned"}, {31'b0, misaligned}, 32'h0);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] raddr;
        bit          rload;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        RESET      = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        prev_valid = 1'b0;
        prev_data  = 32'h0;

        repeat (2) @(negedge CLK);
        checkAllZero("reset");
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        applyStimulus(1, 0, 1, F3_W, 32'h00, 32'hDEADBEEF);
        applyStimulus(1, 1, 0, F3_W, 32'h00, 32'h0);
        applyStimulus(1, 0, 1, F3_W, 32'h30, 32'h12345678);
        applyStimulus(1, 1, 0, F3_B, 32'h33, 32'h0);
        applyStimulus(1, 0, 1, F3_B, 32'h34, 32'h00000080);
        applyStimulus(1, 1, 0, F3_B, 32'h34, 32'h0);
        applyStimulus(1, 1, 0, F3_BU, 32'h34, 32'h0);
        applyStimulus(1, 1, 0, F3_H, 32'h32, 32'h0);
        applyStimulus(1, 0, 1, F3_W, 32'h41, 32'h11223344);
        applyStimulus(1, 1, 0, F3_W, 32'h40, 32'h0);
        applyStimulus(1, 1, 0, F3_W, 32'h44, 32'h0);
        applyStimulus(1, 1, 0, F3_H, 32'h43, 32'h0);
        applyStimulus(1, 1, 0, F3_HU, 32'h41, 32'h0);
        applyStimulus(1, 1, 0, 3'b011, 32'h40, 32'h0);
        applyStimulus(0, 0, 1, F3_B, 32'h60, 32'hA5);
        applyStimulus(1, 0, 1, F3_BU, 32'h60, 32'hA5);
        applyStimulus(1, 1, 1'b0, 3'b110, 32'h20, 32'h0);
        applyStimulus(1, 0, 1, F3_W, 32'hFFFFFFFE, 32'hCAFEF00D);
        applyStimulus(1, 1, 0, F3_W, 32'hFFFFFFFE, 32'h0);
        applyStimulus(1, 1, 0, F3_H, 32'hFFFFFFFF, 32'h0);
        applyStimulus(0, 0, 0, F3_B, 32'h0, 32'h0);

        // Misaligned word store at 0x51 interrupted by reset in its third cycle.
        req_valid  = 1'b1;
        req_load   = 1'b0;
        req_store  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h51;
        req_wdata  = 32'hAABBCCDD;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        checkAllZero("midreset");
        @(posedge CLK);
        #1;
        RESET     = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        ref_mem[8'h51] = 8'hDD;
        ref_mem[8'h52] = 8'hCC;
        prev_valid = 1'b0;
        prev_data  = 32'h0;
        applyStimulus(1, 1, 0, F3_W, 32'h50, 32'h0);
        applyStimulus(1, 1, 0, F3_W, 32'h54, 32'h0);

        for (int n = 0; n < 250; n++) begin
            rf3   = 3'($urandom_range(0, 7));
            rload = $urandom_range(0, 1) == 1;
            raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            applyStimulus($urandom_range(0, 7) != 0, rload, !rload, rf3, raddr, $urandom);
        end
        applyStimulus(0, 0, 0, F3_B, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
